// File: rtl/alu_pkg.sv
// Shared constants for the EX-stage ALU: datapath width and the 5-bit operation codes.
package alu_pkg;

  localparam int WIDTH = 32;

  localparam logic [4:0] ALU_AND    = 5'b00000;
  localparam logic [4:0] ALU_OR     = 5'b00001;
  localparam logic [4:0] ALU_ADD    = 5'b00010;
  localparam logic [4:0] ALU_SUB    = 5'b00011;
  localparam logic [4:0] ALU_SLL    = 5'b00100;
  localparam logic [4:0] ALU_SLT    = 5'b00101;
  localparam logic [4:0] ALU_SLTU   = 5'b00110;
  localparam logic [4:0] ALU_XOR    = 5'b00111;
  localparam logic [4:0] ALU_SRL    = 5'b01000;
  localparam logic [4:0] ALU_SRA    = 5'b01001;
  localparam logic [4:0] ALU_MUL    = 5'b01010;
  localparam logic [4:0] ALU_MULH   = 5'b01011;
  localparam logic [4:0] ALU_MULHSU = 5'b01100;
  localparam logic [4:0] ALU_MULHU  = 5'b01101;
  localparam logic [4:0] ALU_DIV    = 5'b01110;
  localparam logic [4:0] ALU_DIVU   = 5'b01111;
  localparam logic [4:0] ALU_REM    = 5'b10000;
  localparam logic [4:0] ALU_REMU   = 5'b10001;
  localparam logic [4:0] ALU_FWD    = 5'b10010;

endpackage

// File: rtl/alu_muldiv.sv
// Combinational RV32M unit: 64-bit products for MUL/MULH*, sign-magnitude divider for DIV/REM.
module alu_muldiv
  import alu_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       op,
  output logic [WIDTH-1:0] result
);

  logic             a_sext;
  logic             b_sext;
  logic [2*WIDTH-1:0] a_wide;
  logic [2*WIDTH-1:0] b_wide;
  logic [2*WIDTH-1:0] prod;

  logic             div_signed;
  logic             a_neg;
  logic             b_neg;
  logic             div_zero;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] b_safe;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] r_mag;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;

  // Sign-extending to 64 bits makes a modular 64x64 multiply yield the exact signed product.
  always_comb begin
    a_sext = (op == ALU_MULH || op == ALU_MULHSU) && a[WIDTH-1];
    b_sext = (op == ALU_MULH) && b[WIDTH-1];
    a_wide = {{WIDTH{a_sext}}, a};
    b_wide = {{WIDTH{b_sext}}, b};
    prod   = a_wide * b_wide;
  end

  // 0x80000000 / -1 falls out naturally: magnitude 2^31 negates back to 0x80000000, remainder 0.
  always_comb begin
    div_signed = (op == ALU_DIV || op == ALU_REM);
    a_neg      = div_signed && a[WIDTH-1];
    b_neg      = div_signed && b[WIDTH-1];
    div_zero   = (b == '0);
    a_mag      = a_neg ? (~a + 1'b1) : a;
    b_mag      = b_neg ? (~b + 1'b1) : b;
    b_safe     = div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
    q_mag      = a_mag / b_safe;
    r_mag      = a_mag % b_safe;
    quot       = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
    rem        = a_neg ? (~r_mag + 1'b1) : r_mag;
    if (div_zero) begin
      quot = '1;
      rem  = a;
    end
  end

  always_comb begin
    result = '0;
    case (op)
      ALU_MUL:    result = prod[WIDTH-1:0];
      ALU_MULH,
      ALU_MULHSU,
      ALU_MULHU:  result = prod[2*WIDTH-1:WIDTH];
      ALU_DIV,
      ALU_DIVU:   result = quot;
      ALU_REM,
      ALU_REMU:   result = rem;
      default:    result = '0;
    endcase
  end

endmodule

// File: rtl/alu.sv
// EX-stage ALU top: RV32I operations, opcode mux and the registered RESULT (1-cycle latency).
module alu #(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  input  logic [4:0]       ALU_OPERATION,
  output logic [WIDTH-1:0] RESULT
);

  import alu_pkg::*;

  logic [4:0]       shamt;
  logic             lt_signed;
  logic             lt_unsigned;
  logic [WIDTH-1:0] sra_val;
  logic [WIDTH-1:0] md_result;
  logic [WIDTH-1:0] result_nxt;

  alu_muldiv u_muldiv (
    .a      (DATA1),
    .b      (DATA2),
    .op     (ALU_OPERATION),
    .result (md_result)
  );

  always_comb begin
    shamt       = DATA2[4:0];
    lt_signed   = $signed(DATA1) < $signed(DATA2);
    lt_unsigned = DATA1 < DATA2;
    sra_val     = WIDTH'($signed(DATA1) >>> shamt);
  end

  // Unassigned opcodes (10011-11111) deliberately produce zero.
  always_comb begin
    result_nxt = '0;
    case (ALU_OPERATION)
      ALU_AND:    result_nxt = DATA1 & DATA2;
      ALU_OR:     result_nxt = DATA1 | DATA2;
      ALU_ADD:    result_nxt = DATA1 + DATA2;
      ALU_SUB:    result_nxt = DATA1 - DATA2;
      ALU_SLL:    result_nxt = DATA1 << shamt;
      ALU_SLT:    result_nxt = {{(WIDTH-1){1'b0}}, lt_signed};
      ALU_SLTU:   result_nxt = {{(WIDTH-1){1'b0}}, lt_unsigned};
      ALU_XOR:    result_nxt = DATA1 ^ DATA2;
      ALU_SRL:    result_nxt = DATA1 >> shamt;
      ALU_SRA:    result_nxt = sra_val;
      ALU_MUL,
      ALU_MULH,
      ALU_MULHSU,
      ALU_MULHU,
      ALU_DIV,
      ALU_DIVU,
      ALU_REM,
      ALU_REMU:   result_nxt = md_result;
      ALU_FWD:    result_nxt = DATA2;
      default:    result_nxt = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      RESULT <= '0;
    end else begin
      RESULT <= result_nxt;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors with literal expectations plus a per-cycle model compare.
module tb_alu;
  import alu_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [31:0] DATA1;
  logic [31:0] DATA2;
  logic [4:0]  ALU_OPERATION;
  logic [31:0] RESULT;

  int errors = 0;
  int checks = 0;

  alu dut (
    .CLK           (CLK),
    .RESET_N       (RESET_N),
    .DATA1         (DATA1),
    .DATA2         (DATA2),
    .ALU_OPERATION (ALU_OPERATION),
    .RESULT        (RESULT)
  );

  always #5 CLK = ~CLK;

  // Reference computed with 64-bit integer arithmetic straight from the opcode definitions.
  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    int              sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    sh = int'(b[4:0]);
    case (op)
      ALU_AND:    return a & b;
      ALU_OR:     return a | b;
      ALU_ADD:    return 32'(ua + ub);
      ALU_SUB:    return 32'(ua - ub);
      ALU_SLL:    return 32'(ua * (64'd1 << sh));
      ALU_SLT:    return (sa < sb) ? 32'd1 : 32'd0;
      ALU_SLTU:   return (ua < ub) ? 32'd1 : 32'd0;
      ALU_XOR:    return a ^ b;
      ALU_SRL:    return 32'(ua / (64'd1 << sh));
      ALU_SRA:    return 32'(sa >>> sh);
      ALU_MUL:    begin p = ua * ub; return p[31:0]; end
      ALU_MULH:   begin p = sa * sb; return p[63:32]; end
      ALU_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
      ALU_MULHU:  begin p = ua * ub; return p[63:32]; end
      ALU_DIV:    return (b == 0) ? 32'hFFFFFFFF : 32'(sa / sb);
      ALU_DIVU:   return (b == 0) ? 32'hFFFFFFFF : 32'(ua / ub);
      ALU_REM:    return (b == 0) ? a : 32'(sa % sb);
      ALU_REMU:   return (b == 0) ? a : 32'(ua % ub);
      ALU_FWD:    return b;
      default:    return 32'h0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every edge: predict the captured value from what the DUT sampled, check it just after.
  always @(posedge CLK) begin : cmp
    logic [31:0] e;
    e = RESET_N ? model(ALU_OPERATION, DATA1, DATA2) : 32'h0;
    #1;
    check("model", RESULT, e);
  end

  task automatic vec(input string name, input logic [4:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp);
    @(negedge CLK);
    ALU_OPERATION = op;
    DATA1 = a;
    DATA2 = b;
    @(posedge CLK);
    #1;
    check(name, RESULT, exp);
  endtask

  initial begin
    DATA1 = 32'hDEADBEEF;
    DATA2 = 32'h12345678;
    ALU_OPERATION = ALU_ADD;
    RESET_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_hold", RESULT, 32'h0);
    @(negedge CLK);
    RESET_N = 1'b1;

    vec("and",  ALU_AND,  32'hA5A5A5A5, 32'h5A5A5A5A, 32'h00000000);
    vec("or",   ALU_OR,   32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFFFFFF);
    vec("add",  ALU_ADD,  32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFFFFFF);
    vec("sub",  ALU_SUB,  32'hA5A5A5A5, 32'h5A5A5A5A, 32'h4B4B4B4B);
    vec("sll",  ALU_SLL,  32'hA5A5A5A5, 32'h5A5A5A5A, 32'h94000000);
    vec("slt",  ALU_SLT,  32'hA5A5A5A5, 32'h5A5A5A5A, 32'h00000001);
    vec("sltu", ALU_SLTU, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h00000000);
    vec("xor",  ALU_XOR,  32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFFFFFF);
    vec("srl",  ALU_SRL,  32'hA5A5A5A5, 32'h5A5A5A5A, 32'h00000029);
    vec("sra",  ALU_SRA,  32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFFFFE9);
    vec("sll_hi_ignored", ALU_SLL, 32'h00000001, 32'hFFFFFFE4, 32'h00000010);
    vec("sra_pos", ALU_SRA, 32'h70000000, 32'h00000004, 32'h07000000);

    vec("mul",    ALU_MUL,    32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE);
    vec("mulh",   ALU_MULH,   32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF);
    vec("mulhsu", ALU_MULHSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF);
    vec("mulhu",  ALU_MULHU,  32'hFFFFFFFF, 32'h00000002, 32'h00000001);
    vec("mulhsu_negb", ALU_MULHSU, 32'h00000002, 32'hFFFFFFFF, 32'h00000001);
    vec("mulh_negb",   ALU_MULH,   32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFF);

    vec("div",  ALU_DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD);
    vec("rem",  ALU_REM,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF);
    vec("divu", ALU_DIVU, 32'hFFFFFFF9, 32'h00000002, 32'h7FFFFFFC);
    vec("remu", ALU_REMU, 32'hFFFFFFF9, 32'h00000002, 32'h00000001);
    vec("div_negdivisor", ALU_DIV, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD);
    vec("rem_negdivisor", ALU_REM, 32'h00000007, 32'hFFFFFFFE, 32'h00000001);

    vec("div_zero",  ALU_DIV,  32'h12345678, 32'h00000000, 32'hFFFFFFFF);
    vec("rem_zero",  ALU_REM,  32'h12345678, 32'h00000000, 32'h12345678);
    vec("divu_zero", ALU_DIVU, 32'h12345678, 32'h00000000, 32'hFFFFFFFF);
    vec("remu_zero", ALU_REMU, 32'h12345678, 32'h00000000, 32'h12345678);
    vec("div_ovf",   ALU_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    vec("rem_ovf",   ALU_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000);

    vec("fwd",      ALU_FWD, 32'h11111111, 32'hDEADB000, 32'hDEADB000);
    vec("op_11111", 5'b11111, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h00000000);
    vec("op_10011", 5'b10011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);

    // Inputs changed after the edge must not disturb RESULT until the next edge.
    vec("add_small", ALU_ADD, 32'd1, 32'd2, 32'd3);
    #2;
    DATA1 = 32'd100;
    ALU_OPERATION = ALU_SUB;
    #1;
    check("midcycle_hold", RESULT, 32'd3);
    @(posedge CLK);
    #1;
    check("midcycle_next", RESULT, 32'd98);

    // Async reset between edges clears immediately; first capture is the edge after release.
    vec("fwd_pre_reset", ALU_FWD, 32'h0, 32'hDEADB000, 32'hDEADB000);
    #2;
    RESET_N = 1'b0;
    #1;
    check("async_clear", RESULT, 32'h0);
    @(negedge CLK);
    RESET_N = 1'b1;
    #1;
    check("post_release_hold", RESULT, 32'h0);
    @(posedge CLK);
    #1;
    check("first_capture", RESULT, 32'hDEADB000);

    repeat (2) @(posedge CLK);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- 32-bit integer ALU for the RV32IM pipelined processor, placed in the EX stage.
- Computes the RV32I logic, arithmetic, shift and compare operations plus the RV32M multiply and divide operations, selected by a 5-bit operation code.
- RESULT is registered: the value computed from inputs sampled at one CLK rising edge appears after that edge.

Parameters:
- WIDTH, 32, datapath width. Only 32 is supported.

Ports:
- CLK  input  1  system clock; rising-edge active.
- RESET_N  input  1  asynchronous, active-low reset.
- DATA1  input  32  operand A (rs1 / PC).
- DATA2  input  32  operand B (rs2 / immediate).
- ALU_OPERATION  input  5  operation select.
- RESULT  output  32  registered result.

Behaviour:
- Reset: RESET_N low forces RESULT = 32'h00000000 immediately, without waiting for CLK, and holds it while low. The first capture happens on the first CLK rising edge after RESET_N goes high.
- Latency: 1 cycle. Operation is computed combinationally from DATA1, DATA2 and ALU_OPERATION, then captured into RESULT on every CLK rising edge. There is no enable or handshake; a new operation can be issued every cycle.
- Opcode map:
  - 00000 AND: DATA1 & DATA2.
  - 00001 OR: DATA1 | DATA2.
  - 00010 ADD: DATA1 + DATA2, mod 2^32, no overflow flag.
  - 00011 SUB: DATA1 - DATA2, mod 2^32.
  - 00100 SLL: DATA1 << DATA2[4:0].
  - 00101 SLT: 1 if signed DATA1 < signed DATA2, else 0; zero-extended to 32 bits.
  - 00110 SLTU: same as SLT with unsigned compare.
  - 00111 XOR: DATA1 ^ DATA2.
  - 01000 SRL: logical DATA1 >> DATA2[4:0].
  - 01001 SRA: arithmetic DATA1 >>> DATA2[4:0], sign-filled.
  - 01010 MUL: low 32 bits of DATA1 * DATA2.
  - 01011 MULH: high 32 bits of signed x signed product.
  - 01100 MULHSU: high 32 bits of signed DATA1 x unsigned DATA2.
  - 01101 MULHU: high 32 bits of unsigned x unsigned product.
  - 01110 DIV: signed quotient, truncated toward zero.
  - 01111 DIVU: unsigned quotient.
  - 10000 REM: signed remainder; sign follows the dividend.
  - 10001 REMU: unsigned remainder.
  - 10010 FWD: RESULT = DATA2 (used for LUI).
  - 10011-11111: RESULT = 0.
- Shift amounts use only DATA2[4:0]; DATA2[31:5] is ignored.
- Divide by zero (DATA2 = 0):
  - DIV and DIVU give 32'hFFFFFFFF.
  - REM and REMU give DATA1.
- Signed overflow (DATA1 = 32'h80000000, DATA2 = 32'hFFFFFFFF):
  - DIV gives 32'h80000000.
  - REM gives 0.
- Inputs changing mid-cycle have no effect until the next rising edge.
- Reset asserted mid-stream discards the pending result.

Decomposition:
- Shared package alu_pkg holds:
  - the 5-bit opcode localparams ALU_AND through ALU_FWD, with the values listed above;
  - the WIDTH constant.
- One sub-module, alu_muldiv: combinational M-extension unit with 64-bit products and a divider, including the divide-by-zero and overflow rules.
- The top level contains the RV32I operations, the opcode mux and the RESULT register.

Test Plan:
- Reset: hold RESET_N low with DATA1/DATA2 nonzero, toggle CLK -> RESULT = 0. Assert RESET_N low between clock edges -> RESULT clears immediately.
- RV32I sweep with DATA1 = A5A5A5A5, DATA2 = 5A5A5A5A; check RESULT one edge after each opcode:
  - AND 00000000, OR FFFFFFFF, ADD FFFFFFFF, SUB 4B4B4B4B;
  - SLL 94000000, SLT 00000001, SLTU 00000000, XOR FFFFFFFF;
  - SRL 00000029, SRA FFFFFFE9.
- Multiply, DATA1 = FFFFFFFF, DATA2 = 00000002:
  - MUL FFFFFFFE, MULH FFFFFFFF, MULHSU FFFFFFFF, MULHU 00000001.
- Divide:
  - DATA1 = FFFFFFF9 (-7), DATA2 = 00000002: DIV FFFFFFFD, REM FFFFFFFF, DIVU 7FFFFFFC, REMU 00000001.
- Corners:
  - DATA2 = 0 with DATA1 = 12345678: DIV FFFFFFFF, REM 12345678.
  - 80000000 / FFFFFFFF: DIV 80000000, REM 00000000.
- FWD with DATA2 = DEADB000 -> DEADB000. Opcode 11111 -> 00000000. Back-to-back opcode changes every cycle -> each result appears exactly one edge later.
